// File: rtl/tiehi_seq_ctrl_if.sv
// Control-side signals of the sequenced tie-high source.
// master drives the request/readback side, slave is the tie controller.
interface tiehi_seq_ctrl_if;
   logic en;
   logic fb;
   logic clr_flt;
   logic a0;
   logic rdy;
   logic flt;

   modport master (
      output en,
      output fb,
      output clr_flt,
      input  a0,
      input  rdy,
      input  flt
   );

   modport slave (
      input  en,
      input  fb,
      input  clr_flt,
      output a0,
      output rdy,
      output flt
   );
endinterface

// File: rtl/tiehi_seq_ctrl.sv
// Sequenced tie-high source: holds a0 low through reset and a settle window,
// then releases it and latches a sticky fault on a persistent readback mismatch.
//
// state  | meaning
// OFF    | tie held low, waiting for en
// SETTLE | en seen, counting the settle window, tie still low
// ON     | tie released high, readback monitored
// FAULT  | sticky fault, tie low until clr_flt
module tiehi_seq_ctrl #(
   parameter int unsigned SETTLE_CYCLES = 16,
   parameter int unsigned DEB_CYCLES    = 4,
   parameter int unsigned CW            = 8
) (
   input logic              CELCLK,
   input logic              CELRSTN,
   input logic              CELV,
   input logic              CELG,
   input logic              SUB,
   tiehi_seq_ctrl_if.slave  bus
);

   localparam logic [1:0] ST_OFF    = 2'd0;
   localparam logic [1:0] ST_SETTLE = 2'd1;
   localparam logic [1:0] ST_ON     = 2'd2;
   localparam logic [1:0] ST_FAULT  = 2'd3;

   localparam logic [CW-1:0] SET_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DEB_TH   = CW'(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX  = '1;

   logic [1:0]    state, state_nxt;
   logic [CW-1:0] scnt, scnt_nxt;
   logic [CW-1:0] dcnt, dcnt_nxt, dcnt_inc;
   logic          fb_m, fb_s;

   // Rails exist only so the brick netlist keeps its pins.
   logic pwr_unused;
   assign pwr_unused = CELV ^ CELG ^ SUB;

   always_ff @(posedge CELCLK or negedge CELRSTN) begin
      if (!CELRSTN) begin
         fb_m  <= 1'b0;
         fb_s  <= 1'b0;
         state <= ST_OFF;
         scnt  <= '0;
         dcnt  <= '0;
      end else begin
         fb_m  <= bus.fb;
         fb_s  <= fb_m;
         state <= state_nxt;
         scnt  <= scnt_nxt;
         dcnt  <= dcnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      scnt_nxt  = scnt;
      dcnt_nxt  = dcnt;
      dcnt_inc  = (dcnt == CNT_MAX) ? dcnt : dcnt + CW'(1);
      case (state)
         ST_OFF: begin
            scnt_nxt = '0;
            dcnt_nxt = '0;
            if (bus.en) state_nxt = ST_SETTLE;
         end
         ST_SETTLE: begin
            if (!bus.en) begin
               state_nxt = ST_OFF;
               scnt_nxt  = '0;
            end else if (scnt >= SET_LAST) begin
               state_nxt = ST_ON;
               scnt_nxt  = '0;
               dcnt_nxt  = '0;
            end else begin
               scnt_nxt = scnt + CW'(1);
            end
         end
         ST_ON: begin
            dcnt_nxt = fb_s ? '0 : dcnt_inc;
            // A threshold hit outranks a simultaneous en drop.
            if (!fb_s && (dcnt_inc >= DEB_TH)) state_nxt = ST_FAULT;
            else if (!bus.en)                  state_nxt = ST_OFF;
         end
         ST_FAULT: begin
            dcnt_nxt = '0;
            if (bus.clr_flt) state_nxt = ST_OFF;
         end
         default: state_nxt = ST_OFF;
      endcase
   end

   assign bus.a0  = (state == ST_ON);
   assign bus.rdy = (state == ST_ON);
   assign bus.flt = (state == ST_FAULT);

endmodule

// File: tb/tb_tiehi_seq_ctrl.sv
// Bench for tiehi_seq_ctrl: per-cycle vector table with hand-derived expected
// outputs, routed through a scoreboard queue, plus an async reset mid-ON.
module tb_tiehi_seq_ctrl;

   logic clk;
   logic rst_n;

   tiehi_seq_ctrl_if bus ();

   tiehi_seq_ctrl #(
      .SETTLE_CYCLES (16),
      .DEB_CYCLES    (4),
      .CW            (8)
   ) dut (
      .CELCLK  (clk),
      .CELRSTN (rst_n),
      .CELV    (1'b1),
      .CELG    (1'b0),
      .SUB     (1'b0),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int   seg;
      logic rst_mid;
      logic en;
      logic fb;
      logic clr;
      logic a0;
      logic rdy;
      logic flt;
   } vec_t;

   typedef struct {
      int   seg;
      logic a0;
      logic rdy;
      logic flt;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s got %b want %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input int seg, input int n, input logic en, input logic fb,
                      input logic clr, input logic a0, input logic rdy,
                      input logic flt, input logic rm = 1'b0);
      vec_t v;
      for (int k = 0; k < n; k++) begin
         v.seg = seg; v.en = en; v.fb = fb; v.clr = clr;
         v.a0 = a0; v.rdy = rdy; v.flt = flt;
         v.rst_mid = (k == 0) ? rm : 1'b0;
         vecs.push_back(v);
      end
   endtask

   initial begin
      exp_t e;
      vec_t v;

      // seg | n | en fb clr | a0 rdy flt
      add( 1,  2, 0, 1, 0, 0, 0, 0);
      add( 2, 16, 1, 1, 0, 0, 0, 0);
      add( 3,  4, 1, 1, 0, 1, 1, 0);
      add( 4,  2, 0, 1, 0, 0, 0, 0);
      add( 5,  8, 1, 1, 0, 0, 0, 0);
      add( 6,  1, 0, 1, 0, 0, 0, 0);
      add( 7, 16, 1, 1, 0, 0, 0, 0);
      add( 8,  1, 1, 1, 0, 1, 1, 0);
      add( 9,  2, 1, 1, 1, 1, 1, 0);
      add(10,  3, 1, 0, 0, 1, 1, 0);
      add(11,  5, 1, 1, 0, 1, 1, 0);
      add(12,  4, 1, 0, 0, 1, 1, 0);
      add(13,  1, 1, 1, 0, 1, 1, 0);
      add(14,  3, 1, 1, 0, 0, 0, 1);
      add(15,  1, 1, 1, 1, 0, 0, 0);
      add(16, 16, 1, 1, 0, 0, 0, 0);
      add(17,  2, 1, 1, 0, 1, 1, 0);
      add(18,  4, 1, 0, 0, 1, 1, 0);
      add(19,  1, 1, 1, 0, 1, 1, 0);
      add(20,  1, 0, 1, 0, 0, 0, 1);
      add(21,  1, 0, 1, 0, 0, 0, 1);
      add(22,  1, 0, 1, 1, 0, 0, 0);
      add(23,  1, 0, 1, 0, 0, 0, 0);
      add(24, 16, 1, 1, 0, 0, 0, 0);
      add(25,  3, 1, 1, 0, 1, 1, 0);
      add(26, 16, 1, 1, 0, 0, 0, 0, 1'b1);
      add(27,  2, 1, 1, 0, 1, 1, 0);

      bus.en = 1'b0; bus.fb = 1'b1; bus.clr_flt = 1'b0;
      rst_n = 1'b0;
      #12;
      chk("reset_a0",  bus.a0,  1'b0);
      chk("reset_rdy", bus.rdy, 1'b0);
      chk("reset_flt", bus.flt, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         v = vecs[i];
         if (v.rst_mid) begin
            // Pull reset between edges while ON; outputs must drop without a clock.
            #2;
            rst_n = 1'b0;
            #1;
            chk("async_rst_a0",  bus.a0,  1'b0);
            chk("async_rst_rdy", bus.rdy, 1'b0);
            chk("async_rst_flt", bus.flt, 1'b0);
            @(negedge clk);
            rst_n = 1'b1;
         end else begin
            @(negedge clk);
         end
         bus.en = v.en; bus.fb = v.fb; bus.clr_flt = v.clr;
         e.seg = v.seg; e.a0 = v.a0; e.rdy = v.rdy; e.flt = v.flt;
         sb.push_back(e);
         @(posedge clk);
         #1;
         if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard_empty got 0 entries want 1");
         end else begin
            e = sb.pop_front();
            chk($sformatf("seg%0d_v%0d_a0",  e.seg, i), bus.a0,  e.a0);
            chk($sformatf("seg%0d_v%0d_rdy", e.seg, i), bus.rdy, e.rdy);
            chk($sformatf("seg%0d_v%0d_flt", e.seg, i), bus.flt, e.flt);
         end
      end

      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain got %0d entries want 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout got running want finished");
      $fatal(1, "timeout");
   end

endmodule
